motor_pulse_modulator: RTL and testbench
========================================

Name: motor_pulse_modulator

Overview:
- Multi-channel successor to the single-channel motor pulse modulator. Generates the actual RC/ESC servo pulse train on each channel, not just a pulse-width value.
- Power is throttled by replacing a fraction of drive frames with neutral frames.
- The fixed per-state lookup table is replaced by a per-channel error accumulator. Drive frames are therefore spread evenly for any power level and any LEVEL_BITS.
- Sits between the navigation state machine (the command source) and the motor controller pins.

Parameters:
- CLK_RATE, 100000000: clock frequency in Hz (documentation only; the cycle parameters below are authoritative).
- CHANNELS, 2: number of independent motor channels.
- CHAN_W, 1: width of cmd_chan; must satisfy 2^CHAN_W >= CHANNELS.
- LEVEL_BITS, 3: throttle level width. Level L gives power (2^LEVEL_BITS - L)/2^LEVEL_BITS.
- CNT_W, 21: frame counter width; must hold FRAME_CYCLES-1.
- FRAME_CYCLES, 2000000: frame period in clocks (20 ms).
- PULSE_FWD, 100000: forward pulse width in clocks (1 ms).
- PULSE_NEU, 150000: neutral pulse width in clocks (1.5 ms).
- PULSE_REV, 200000: reverse pulse width in clocks (2 ms).
- Constraint: 0 < PULSE_* < FRAME_CYCLES.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous, active-high reset.
- cmd_we, in, 1: command write strobe (single cycle).
- cmd_chan, in, CHAN_W: target channel.
- cmd_dir, in, 2: direction code. 0 = forward, 1 = neutral, 2 = reverse, 3 = neutral (brake alias).
- cmd_level, in, LEVEL_BITS: throttle level; 0 = 100% power.
- pwm_out, out, CHANNELS: servo pulse outputs, one bit per channel.
- drive_en, out, CHANNELS: 1 when this frame carries the commanded direction; 0 when substituted neutral.
- frame_start, out, 1: one-cycle strobe on the first cycle of each frame.
- frame_idx, out, 8: frame counter; wraps 255 -> 0.

Behaviour:
- There is one clock (CLK) and reset is synchronous and active-high (RST). Reset polarity and synchronicity are fixed.
- All outputs are registered.

Reset values:
- cnt = FRAME_CYCLES-1, so the first cycle after reset is a frame boundary.
- pwm_out = 0, drive_en = 0, frame_start = 0, frame_idx = 0.
- Per channel: shadow and active dir = 1, level = 0, acc = 0.

Frame counter:
- cnt runs 0..FRAME_CYCLES-1, then wraps to 0.
- The cycle with cnt == 0 is frame start: frame_start = 1 on exactly that cycle.
- frame_idx increments on each frame start. The first frame after reset shows frame_idx = 1.

Command path:
- When cmd_we = 1 and cmd_chan < CHANNELS, {cmd_dir, cmd_level} are written to that channel's shadow register.
- Writes with cmd_chan >= CHANNELS are ignored.
- Shadow registers are copied to the active registers only at frame start. Pulses are never truncated or stretched mid-frame.
- Write on the last cycle of a frame (cnt == FRAME_CYCLES-1): takes effect in the frame starting next cycle (write-through to the active registers).
- Two writes to the same channel within one frame: the last one wins.

Modulation per channel, evaluated at frame start:
- N = 2^LEVEL_BITS; inc = N - level.
- If the active level changed this frame, acc is cleared to 0 before the update.
- a = acc + inc, computed at LEVEL_BITS+2 bits.
- drive = (a >= N); acc <= drive ? a - N : a.
- Level 0 is always drive.
- Level L produces exactly N-L drive frames in every N consecutive frames after a level change. The first drive frame occurs at frame ceil(N/inc) (1-based).

Pulse width and output:
- width = drive ? dir_pulse : PULSE_NEU, where dir_pulse = PULSE_FWD, PULSE_NEU or PULSE_REV by dir (dir 3 uses PULSE_NEU).
- drive_en = drive, held for the whole frame.
- pwm_out[ch] = 1 on the cycles where cnt is in 0..width-1, else 0. High time is exactly width clocks per frame; the rising edge coincides with frame_start.

Mid-operation reset:
- RST mid-frame forces all reset values on the next edge.
- A new frame begins on the cycle after RST deasserts, with all channels neutral.
- Pulses are cut short; no glitch beyond that is permitted.

Channels are fully independent and share only the frame counter.

Test Plan:
All scenarios use FRAME_CYCLES=1000, PULSE_FWD=100, PULSE_NEU=150, PULSE_REV=200, CHANNELS=2, LEVEL_BITS=3.
- Reset then idle 3 frames -> frame_start at cycles 1, 1001, 2001. Both pwm_out high for exactly 150 clocks per frame. drive_en = 0b11 (neutral commanded, level 0). frame_idx = 1, 2, 3.
- Write ch0 dir=0 level=0 mid-frame -> current frame stays 150 clocks. Every following frame is 100 clocks. ch1 is unaffected.
- ch1 dir=2 level=4 -> ch1 frames alternate 150, 200, 150, 200 (neutral first). drive_en[1] follows the pattern. Over 8 frames: 4 drive frames.
- ch0 dir=0 level=7 -> exactly 1 drive frame (100 clocks) in every 8, at frame 8 after the change. Level 1 -> 7 of 8 frames drive.
- Write on cycle cnt==999 (ch0 dir=2) -> the next frame already has a 200-clock pulse. A write with cmd_chan=1 on the same cycle updates ch1 identically. A write with cmd_chan out of range (with a CHANNELS=3, CHAN_W=2 build, cmd_chan=3) -> no channel changes.
- RST asserted at cnt=50 of a 200-clock pulse -> pwm_out low next cycle. New frame starts the cycle after RST falls, at 150 clocks, with frame_idx = 1.

Source files
------------

// File: rtl/motor_pulse_modulator.sv
// Multi-channel RC/ESC servo pulse generator with error-accumulator power throttling.
// All channels share one frame counter and latch their command only at frame start.

module motor_pulse_chan #(
  parameter int LEVEL_BITS = 3,
  parameter int CNT_W      = 21,
  parameter int PULSE_FWD  = 100000,
  parameter int PULSE_NEU  = 150000,
  parameter int PULSE_REV  = 200000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr,
  input  logic [1:0]            wr_dir,
  input  logic [LEVEL_BITS-1:0] wr_level,
  input  logic                  wrap,
  input  logic [CNT_W-1:0]      cnt_nxt,
  output logic                  pwm,
  output logic                  drive_en
);
  typedef struct packed {
    logic [1:0]            dir;
    logic [LEVEL_BITS-1:0] level;
  } cmd_t;

  localparam int               AW      = LEVEL_BITS + 2;
  localparam logic [AW-1:0]    N       = AW'(1 << LEVEL_BITS);
  localparam logic [CNT_W-1:0] W_FWD   = CNT_W'(PULSE_FWD);
  localparam logic [CNT_W-1:0] W_NEU   = CNT_W'(PULSE_NEU);
  localparam logic [CNT_W-1:0] W_REV   = CNT_W'(PULSE_REV);
  localparam cmd_t             CMD_RST = '{dir: 2'd1, level: '0};

  cmd_t             shadow, active, wr_cmd, act_nxt;
  logic [AW-1:0]    acc, acc_base, acc_sum, acc_nxt;
  logic             drive_nxt;
  logic [CNT_W-1:0] width, width_nxt;

  // A write landing on the wrap cycle bypasses the shadow so it still makes this frame.
  always_comb begin
    wr_cmd    = '{dir: wr_dir, level: wr_level};
    act_nxt   = wr ? wr_cmd : shadow;
    acc_base  = (act_nxt.level != active.level) ? '0 : acc;
    acc_sum   = acc_base + (N - AW'(act_nxt.level));
    drive_nxt = (acc_sum >= N);
    acc_nxt   = drive_nxt ? acc_sum - N : acc_sum;
    width_nxt = width;
    if (wrap) begin
      width_nxt = W_NEU;
      if (drive_nxt) begin
        case (act_nxt.dir)
          2'd0:    width_nxt = W_FWD;
          2'd2:    width_nxt = W_REV;
          default: width_nxt = W_NEU;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow   <= CMD_RST;
      active   <= CMD_RST;
      acc      <= '0;
      width    <= W_NEU;
      pwm      <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      if (wr) shadow <= wr_cmd;
      if (wrap) begin
        active   <= act_nxt;
        acc      <= acc_nxt;
        drive_en <= drive_nxt;
      end
      width <= width_nxt;
      pwm   <= (cnt_nxt < width_nxt);
    end
  end
endmodule

module motor_pulse_modulator #(
  parameter int CLK_RATE     = 100000000,
  parameter int CHANNELS     = 2,
  parameter int CHAN_W       = 1,
  parameter int LEVEL_BITS   = 3,
  parameter int CNT_W        = 21,
  parameter int FRAME_CYCLES = 2000000,
  parameter int PULSE_FWD    = 100000,
  parameter int PULSE_NEU    = 150000,
  parameter int PULSE_REV    = 200000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_we,
  input  logic [CHAN_W-1:0]     cmd_chan,
  input  logic [1:0]            cmd_dir,
  input  logic [LEVEL_BITS-1:0] cmd_level,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic [CHANNELS-1:0]   drive_en,
  output logic                  frame_start,
  output logic [7:0]            frame_idx
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  if (CLK_RATE <= 0 || (64'd1 << CHAN_W) < 64'(CHANNELS) ||
      64'(FRAME_CYCLES) > (64'd1 << CNT_W) || FRAME_CYCLES <= PULSE_REV ||
      FRAME_CYCLES <= PULSE_NEU || FRAME_CYCLES <= PULSE_FWD) begin : g_param_err
    $error("motor_pulse_modulator: inconsistent parameters");
  end

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wrap;

  assign wrap    = (cnt == CNT_LAST);
  assign cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);

  // Reset parks the counter on the last cycle so the first cycle out of reset opens a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt         <= CNT_LAST;
      frame_start <= 1'b0;
      frame_idx   <= '0;
    end else begin
      cnt         <= cnt_nxt;
      frame_start <= wrap;
      if (wrap) frame_idx <= frame_idx + 8'd1;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    motor_pulse_chan #(
      .LEVEL_BITS (LEVEL_BITS),
      .CNT_W      (CNT_W),
      .PULSE_FWD  (PULSE_FWD),
      .PULSE_NEU  (PULSE_NEU),
      .PULSE_REV  (PULSE_REV)
    ) u_chan (
      .CLK      (CLK),
      .RST      (RST),
      .wr       (cmd_we && (cmd_chan == CHAN_W'(ch))),
      .wr_dir   (cmd_dir),
      .wr_level (cmd_level),
      .wrap     (wrap),
      .cnt_nxt  (cnt_nxt),
      .pwm      (pwm_out[ch]),
      .drive_en (drive_en[ch])
    );
  end
endmodule

// File: tb/tb_motor_pulse_modulator.sv
// Scoreboarded bench: expected per-frame pulse widths are queued as commands are driven
// and compared by a frame monitor as each frame completes.

module tb_motor_pulse_modulator;
  localparam int FRAME = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_we = 1'b0;
  logic [0:0] cmd_chan = '0;
  logic [1:0] cmd_dir = '0;
  logic [2:0] cmd_level = '0;
  logic [1:0] pwm_out, drive_en;
  logic       frame_start;
  logic [7:0] frame_idx;

  logic       cmd_we3 = 1'b0;
  logic [1:0] cmd_chan3 = '0;
  logic [1:0] cmd_dir3 = '0;
  logic [2:0] cmd_level3 = '0;
  logic [2:0] pwm3, de3;
  logic       fs3;
  logic [7:0] fidx3;

  always #5 clk = ~clk;

  motor_pulse_modulator #(
    .CHANNELS(2), .CHAN_W(1), .LEVEL_BITS(3), .CNT_W(21), .FRAME_CYCLES(FRAME),
    .PULSE_FWD(100), .PULSE_NEU(150), .PULSE_REV(200)
  ) u_dut (
    .CLK(clk), .RST(rst), .cmd_we(cmd_we), .cmd_chan(cmd_chan), .cmd_dir(cmd_dir),
    .cmd_level(cmd_level), .pwm_out(pwm_out), .drive_en(drive_en),
    .frame_start(frame_start), .frame_idx(frame_idx)
  );

  motor_pulse_modulator #(
    .CHANNELS(3), .CHAN_W(2), .LEVEL_BITS(3), .CNT_W(21), .FRAME_CYCLES(FRAME),
    .PULSE_FWD(100), .PULSE_NEU(150), .PULSE_REV(200)
  ) u_dut3 (
    .CLK(clk), .RST(rst), .cmd_we(cmd_we3), .cmd_chan(cmd_chan3), .cmd_dir(cmd_dir3),
    .cmd_level(cmd_level3), .pwm_out(pwm3), .drive_en(de3),
    .frame_start(fs3), .frame_idx(fidx3)
  );

  // Bench-side frame position model.
  int tb_cnt = FRAME - 1;
  int tb_frame = 0;
  always @(posedge clk) begin
    if (rst) begin
      tb_cnt   <= FRAME - 1;
      tb_frame <= 0;
    end else if (tb_cnt == FRAME - 1) begin
      tb_cnt   <= 0;
      tb_frame <= tb_frame + 1;
    end else begin
      tb_cnt <= tb_cnt + 1;
    end
  end

  typedef struct {
    int         w0;
    int         w1;
    logic [1:0] de;
    logic [7:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   n_checks = 0;
  int   n_fail = 0;

  int         hi0 = 0, hi1 = 0, per = 0;
  logic [1:0] fell = '0, de_cur = '0;
  logic [7:0] idx_cur = '0;
  bit         in_frame = 0, shape_ok = 1;

  function automatic void push(input int f, input int w0, input int w1, input logic [1:0] de);
    exp_t e;
    e.w0 = w0; e.w1 = w1; e.de = de; e.idx = 8'(f);
    exp_q.push_back(e);
  endfunction

  // Frame monitor: closes a frame at the next frame_start and scores it.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
    end else begin
      if (frame_start) begin
        if (in_frame && exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          n_checks++;
          if (hi0 !== sb_e.w0 || hi1 !== sb_e.w1 || de_cur !== sb_e.de ||
              idx_cur !== sb_e.idx || per !== FRAME) begin
            n_fail++;
            $display("FAIL frame_%0d: got w0=%0d w1=%0d de=%b idx=%0d period=%0d, want w0=%0d w1=%0d de=%b idx=%0d period=%0d",
                     sb_e.idx, hi0, hi1, de_cur, idx_cur, per, sb_e.w0, sb_e.w1, sb_e.de, sb_e.idx, FRAME);
          end
          n_checks++;
          if (!shape_ok) begin
            n_fail++;
            $display("FAIL frame_shape_%0d: got clean=0, want clean=1 (single pulse from frame_start, stable drive_en/frame_idx)",
                     sb_e.idx);
          end
        end
        in_frame = 1;
        per      = 0;
        hi0      = 0;
        hi1      = 0;
        fell     = '0;
        de_cur   = drive_en;
        idx_cur  = frame_idx;
        shape_ok = (pwm_out == 2'b11);
      end
      if (in_frame) begin
        per++;
        if (pwm_out[0]) begin hi0++; if (fell[0]) shape_ok = 0; end else fell[0] = 1'b1;
        if (pwm_out[1]) begin hi1++; if (fell[1]) shape_ok = 0; end else fell[1] = 1'b1;
        if (drive_en !== de_cur || frame_idx !== idx_cur) shape_ok = 0;
      end
    end
  end

  task automatic goto(input int f, input int k);
    for (int i = 0; i < 60000; i++) begin
      if (tb_frame == f && tb_cnt == k) break;
      @(negedge clk);
    end
  endtask

  task automatic write0(input logic ch, input logic [1:0] dir, input logic [2:0] lvl);
    cmd_we = 1'b1; cmd_chan = ch; cmd_dir = dir; cmd_level = lvl;
    @(negedge clk);
    cmd_we = 1'b0;
  endtask

  task automatic write3(input logic [1:0] ch, input logic [1:0] dir, input logic [2:0] lvl);
    cmd_we3 = 1'b1; cmd_chan3 = ch; cmd_dir3 = dir; cmd_level3 = lvl;
    @(negedge clk);
    cmd_we3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_out !== 2'b00 || drive_en !== 2'b00 || frame_start !== 1'b0 || frame_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got pwm=%b de=%b fs=%b idx=%0d, want 00 00 0 0", pwm_out, drive_en, frame_start, frame_idx);
    end
    n_checks++;
    if (pwm3 !== 3'b000 || de3 !== 3'b000 || fs3 !== 1'b0 || fidx3 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state3: got pwm=%b de=%b fs=%b idx=%0d, want 000 000 0 0", pwm3, de3, fs3, fidx3);
    end
    for (int f = 1; f <= 3; f++) push(f, 150, 150, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b1 || frame_idx !== 8'd1 || pwm_out !== 2'b11 || drive_en !== 2'b11) begin
      n_fail++;
      $display("FAIL first_frame: got fs=%b idx=%0d pwm=%b de=%b, want 1 1 11 11", frame_start, frame_idx, pwm_out, drive_en);
    end
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_one_cycle: got %b, want 0", frame_start);
    end
    goto(4, 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_frames: got %0d unscored frames, want 0", exp_q.size());
    end
  endtask

  task automatic test_forward();
    goto(4, 500);
    push(4, 150, 150, 2'b11);
    push(5, 100, 150, 2'b11);
    push(6, 100, 150, 2'b11);
    write0(1'b0, 2'd0, 3'd0);
    goto(5, 99);
    n_checks++;
    if (pwm_out !== 2'b11) begin
      n_fail++;
      $display("FAIL fwd_high_edge: got pwm=%b, want 11", pwm_out);
    end
    goto(5, 100);
    n_checks++;
    if (pwm_out !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_fall_edge: got pwm=%b, want 10", pwm_out);
    end
    goto(7, 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fwd_frames: got %0d unscored frames, want 0", exp_q.size());
    end
  endtask

  task automatic test_level4();
    int nd;
    goto(7, 300);
    push(7, 100, 150, 2'b11);
    for (int f = 8; f <= 15; f++)
      push(f, 100, (f % 2 == 1) ? 200 : 150, {f % 2 == 1, 1'b1});
    write0(1'b1, 2'd2, 3'd4);
    nd = 0;
    for (int f = 8; f <= 15; f++) begin
      goto(f, 500);
      nd += int'(drive_en[1]);
    end
    n_checks++;
    if (nd != 4) begin
      n_fail++;
      $display("FAIL level4_count: got %0d drive frames, want 4", nd);
    end
    goto(16, 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL level4_frames: got %0d unscored frames, want 0", exp_q.size());
    end
  endtask

  task automatic test_level7();
    int nd;
    goto(16, 300);
    push(16, 100, 150, 2'b01);
    for (int f = 17; f <= 24; f++)
      push(f, (f == 24) ? 100 : 150, (f % 2 == 1) ? 200 : 150, {f % 2 == 1, f == 24});
    write0(1'b0, 2'd0, 3'd7);
    nd = 0;
    for (int f = 17; f <= 24; f++) begin
      goto(f, 500);
      nd += int'(drive_en[0]);
    end
    n_checks++;
    if (nd != 1) begin
      n_fail++;
      $display("FAIL level7_count: got %0d drive frames, want 1", nd);
    end
    goto(25, 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL level7_frames: got %0d unscored frames, want 0", exp_q.size());
    end
  endtask

  task automatic test_level1();
    int nd;
    goto(25, 300);
    push(25, 150, 200, 2'b10);
    for (int f = 26; f <= 33; f++)
      push(f, (f == 26) ? 150 : 100, (f % 2 == 1) ? 200 : 150, {f % 2 == 1, f != 26});
    write0(1'b0, 2'd0, 3'd1);
    nd = 0;
    for (int f = 26; f <= 33; f++) begin
      goto(f, 500);
      nd += int'(drive_en[0]);
    end
    n_checks++;
    if (nd != 7) begin
      n_fail++;
      $display("FAIL level1_count: got %0d drive frames, want 7", nd);
    end
    goto(34, 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL level1_frames: got %0d unscored frames, want 0", exp_q.size());
    end
  endtask

  task automatic test_write_through();
    goto(34, 100);
    push(34, 150, 150, 2'b00);
    for (int f = 35; f <= 37; f++) push(f, 200, 200, 2'b11);
    goto(34, 999);
    write0(1'b0, 2'd2, 3'd0);
    n_checks++;
    if (pwm_out[0] !== 1'b1 || drive_en[0] !== 1'b1 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wt_ch0_start: got pwm0=%b de0=%b fs=%b, want 1 1 1", pwm_out[0], drive_en[0], frame_start);
    end
    goto(35, 199);
    n_checks++;
    if (pwm_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wt_ch0_last_high: got %b, want 1", pwm_out[0]);
    end
    goto(35, 200);
    n_checks++;
    if (pwm_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wt_ch0_fall: got %b, want 0", pwm_out[0]);
    end
    goto(35, 999);
    write0(1'b1, 2'd2, 3'd0);
    n_checks++;
    if (drive_en !== 2'b11 || pwm_out !== 2'b11) begin
      n_fail++;
      $display("FAIL wt_ch1_start: got de=%b pwm=%b, want 11 11", drive_en, pwm_out);
    end
    goto(38, 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wt_frames: got %0d unscored frames, want 0", exp_q.size());
    end
  endtask

  task automatic test_out_of_range();
    goto(38, 100);
    write3(2'd3, 2'd0, 3'd0);
    goto(39, 120);
    n_checks++;
    if (pwm3 !== 3'b111 || de3 !== 3'b111) begin
      n_fail++;
      $display("FAIL oor_ignored: got pwm=%b de=%b, want 111 111", pwm3, de3);
    end
    goto(39, 300);
    write3(2'd2, 2'd0, 3'd0);
    goto(40, 120);
    n_checks++;
    if (pwm3 !== 3'b011 || de3 !== 3'b111) begin
      n_fail++;
      $display("FAIL ch2_write: got pwm=%b de=%b, want 011 111", pwm3, de3);
    end
  endtask

  task automatic test_mid_reset();
    goto(41, 49);
    n_checks++;
    if (pwm_out !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: got %b, want 11", pwm_out);
    end
    goto(41, 50);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pwm_out !== 2'b00 || drive_en !== 2'b00 || frame_start !== 1'b0 || frame_idx !== 8'd0 ||
        pwm3 !== 3'b000 || fidx3 !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got pwm=%b de=%b fs=%b idx=%0d pwm3=%b idx3=%0d, want 00 00 0 0 000 0",
               pwm_out, drive_en, frame_start, frame_idx, pwm3, fidx3);
    end
    repeat (2) @(negedge clk);
    push(1, 150, 150, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b1 || frame_idx !== 8'd1 || pwm_out !== 2'b11 || drive_en !== 2'b11 || fs3 !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_frame: got fs=%b idx=%0d pwm=%b de=%b fs3=%b, want 1 1 11 11 1",
               frame_start, frame_idx, pwm_out, drive_en, fs3);
    end
    goto(2, 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_frames: got %0d unscored frames, want 0", exp_q.size());
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_forward();
    test_level4();
    test_level7();
    test_level1();
    test_write_through();
    test_out_of_range();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
